boot_loader: RTL and testbench

- Sits upstream of the 5-stage core top and its main memory.
- Accepts a stream of 32-bit program words over a valid/ready handshake and writes them into the instruction region of memory, starting at INSTR_START_PC.
- Holds the core in reset with memory disabled while loading, then enables memory and releases the core after a fixed settle delay.
- Flags overflow into the data region as a sticky error.

---
 rtl/boot_loader.sv | 190 +++++++++++++++++++
 tb/tb_boot_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : Streams 32-bit program words over a valid/ready handshake
//                into the instruction region of memory, then enables memory
//                and releases the core after a fixed settle delay. Overflow
//                into the data region is reported as a sticky error.
//                Optional feature macro: BOOT_CHECKSUM_EN (adds a CHECK state
//                that compares one extra beat against a running 32-bit sum).
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter logic [31:0] INSTR_START_PC = 32'h0000_0000,
    parameter int          MAX_WORDS      = 128,
    parameter int          RELEASE_CYCLES = 4,
    parameter int          CNT_WIDTH      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 boot_start,
    input  logic                 ld_valid,
    input  logic [31:0]          ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 mem_wr_en,
    output logic [31:0]          mem_wr_addr,
    output logic [31:0]          mem_wr_data,
    output logic                 mem_en,
    output logic                 core_reset,
    output logic                 boot_done,
    output logic                 boot_error,
    output logic [CNT_WIDTH-1:0] words_loaded
);

    localparam int                     c_settle_w    = $clog2(RELEASE_CYCLES + 1);
    localparam logic [c_settle_w-1:0]  c_settle_init = c_settle_w'(RELEASE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   c_max_words   = CNT_WIDTH'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK  = 3'd5,
`endif
        ST_ERROR  = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_ld_ready;
    logic                    r_mem_wr_en;
    logic [31:0]             r_mem_wr_addr;
    logic [31:0]             r_mem_wr_data;
    logic                    r_mem_en;
    logic                    r_core_reset;
    logic                    r_boot_done;
    logic                    r_boot_error;
    logic [CNT_WIDTH-1:0]    r_words_loaded;
    logic [c_settle_w-1:0]   r_settle_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]             r_sum;
`endif

    logic                    w_xfer;
    logic                    w_full;
    logic [31:0]             w_wr_addr;

    // Beat acceptance, region-full detection and the byte address of the next word
    assign w_xfer    = ld_valid && r_ld_ready;
    assign w_full    = (r_words_loaded == c_max_words);
    assign w_wr_addr = INSTR_START_PC + 32'({r_words_loaded, 2'b00});

    // Boot sequencer: all outputs are registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_ld_ready     <= 1'b0;
            r_mem_wr_en    <= 1'b0;
            r_mem_wr_addr  <= INSTR_START_PC;
            r_mem_wr_data  <= 32'h0;
            r_mem_en       <= 1'b0;
            r_core_reset   <= 1'b1;
            r_boot_done    <= 1'b0;
            r_boot_error   <= 1'b0;
            r_words_loaded <= '0;
            r_settle_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum          <= 32'h0;
`endif
        end else begin
            // Write strobe is a one-cycle pulse per accepted word
            r_mem_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (boot_start) begin
                        r_state        <= ST_LOAD;
                        r_ld_ready     <= 1'b1;
                        r_words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum          <= 32'h0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (w_full) begin
                            // Word would land in the data region: drop it and flag
                            r_boot_error <= 1'b1;
                            r_ld_ready   <= 1'b0;
                            r_state      <= ST_ERROR;
                        end else begin
                            r_mem_wr_en    <= 1'b1;
                            r_mem_wr_addr  <= w_wr_addr;
                            r_mem_wr_data  <= ld_data;
                            r_words_loaded <= r_words_loaded + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            r_sum          <= r_sum + ld_data;
                            if (ld_last) begin
                                r_state <= ST_CHECK;
                            end
`else
                            if (ld_last) begin
                                r_ld_ready   <= 1'b0;
                                r_mem_en     <= 1'b1;
                                r_settle_cnt <= c_settle_init;
                                r_state      <= ST_SETTLE;
                            end
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHECK: begin
                    // One extra beat carries the expected sum; it is never written
                    if (w_xfer) begin
                        r_ld_ready <= 1'b0;
                        if (ld_data == r_sum) begin
                            r_mem_en     <= 1'b1;
                            r_settle_cnt <= c_settle_init;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_boot_error <= 1'b1;
                            r_state      <= ST_ERROR;
                        end
                    end
                end
`endif
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_core_reset <= 1'b0;
                        r_boot_done  <= 1'b1;
                        r_state      <= ST_RUN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    // Terminal until reset
                end
                ST_ERROR: begin
                    if (boot_start) begin
                        r_boot_error   <= 1'b0;
                        r_ld_ready     <= 1'b1;
                        r_words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum          <= 32'h0;
`endif
                        r_state        <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_ready     = r_ld_ready;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_en       = r_mem_en;
    assign core_reset   = r_core_reset;
    assign boot_done    = r_boot_done;
    assign boot_error   = r_boot_error;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Self-checking bench for boot_loader with randomized streams
//                and a behavioural model of writes, settle and error outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam logic [31:0] c_start = 32'h0000_0000;
    localparam int          c_max   = 128;
    localparam int          c_rel   = 4;
    localparam int          c_cw    = 8;

    logic            clock;
    logic            reset;
    logic            boot_start;
    logic            ld_valid;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic            ld_ready;
    logic            mem_wr_en;
    logic [31:0]     mem_wr_addr;
    logic [31:0]     mem_wr_data;
    logic            mem_en;
    logic            core_reset;
    logic            boot_done;
    logic            boot_error;
    logic [c_cw-1:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    boot_loader #(
        .INSTR_START_PC (c_start),
        .MAX_WORDS      (c_max),
        .RELEASE_CYCLES (c_rel),
        .CNT_WIDTH      (c_cw)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .boot_start   (boot_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_en       (mem_en),
        .core_reset   (core_reset),
        .boot_done    (boot_done),
        .boot_error   (boot_error),
        .words_loaded (words_loaded)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the next expected (address, data) pair
    always @(negedge clock) begin
        if (mem_wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", mem_wr_addr, mon_e[63:32]);
                check_val("wr_data", mem_wr_data, mon_e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_ld_ready"},     32'(ld_ready), 32'd0);
        check_val({pfx, "_mem_wr_en"},    32'(mem_wr_en), 32'd0);
        check_val({pfx, "_mem_wr_addr"},  mem_wr_addr, c_start);
        check_val({pfx, "_mem_wr_data"},  mem_wr_data, 32'd0);
        check_val({pfx, "_mem_en"},       32'(mem_en), 32'd0);
        check_val({pfx, "_core_reset"},   32'(core_reset), 32'd1);
        check_val({pfx, "_boot_done"},    32'(boot_done), 32'd0);
        check_val({pfx, "_boot_error"},   32'(boot_error), 32'd0);
        check_val({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last, input int gap, output bit ok);
        bit rdy;
        ok = 1'b0;
        ld_valid = 1'b0;
        repeat (gap) step();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        for (int k = 0; k < 50; k++) begin
            rdy = ld_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (!ok) check_val("beat_timeout", 32'd0, 32'd1);
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each beat
    task automatic run_load(input int n, input bit mark_last, input int gap,
                            input bit bad_sum, input bit poke, input bit fixed);
        logic [31:0] w;
        logic [31:0] sum;
        logic [31:0] fixed_words [3];
        int          n_exp;
        int          cnt;
        bit          ok;
        bit          exp_err;
        fixed_words[0] = 32'h0000_0013;
        fixed_words[1] = 32'h0010_0093;
        fixed_words[2] = 32'h0020_8113;
        exp_q.delete();
        n_writes = 0;
        sum      = 32'h0;
        n_exp    = (n > c_max) ? c_max : n;
        exp_err  = (n > c_max);
`ifdef BOOT_CHECKSUM_EN
        exp_err  = exp_err || bad_sum;
`endif
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
        check_val("ready_after_start", 32'(ld_ready), 32'd1);
        check_val("error_after_start", 32'(boot_error), 32'd0);
        check_val("count_after_start", 32'(words_loaded), 32'd0);
        for (int i = 0; i < n; i++) begin
            w = (fixed && i < 3) ? fixed_words[i] : $urandom;
            if (i < c_max) begin
                exp_q.push_back({c_start + 32'(4 * i), w});
                sum = sum + w;
            end
            send_beat(w, mark_last && (i == n - 1), (gap < 0) ? int'($urandom_range(0, 2)) : gap, ok);
            if (!ok) return;
            check_val("count_progress", 32'(words_loaded), 32'((i + 1 > c_max) ? c_max : i + 1));
        end
`ifdef BOOT_CHECKSUM_EN
        if (mark_last) begin
            send_beat(bad_sum ? sum + 32'd1 : sum, 1'($urandom_range(0, 1)), 0, ok);
            if (!ok) return;
        end
`endif
        if (exp_err) begin
            check_val("err_flag", 32'(boot_error), 32'd1);
            check_val("err_mem_en", 32'(mem_en), 32'd0);
            check_val("err_core_reset", 32'(core_reset), 32'd1);
            check_val("err_ready", 32'(ld_ready), 32'd0);
            step();
            check_val("err_core_reset_hold", 32'(core_reset), 32'd1);
        end else begin
            check_val("settle_ready", 32'(ld_ready), 32'd0);
            check_val("settle_mem_en", 32'(mem_en), 32'd1);
            cnt = 0;
            for (int k = 0; k < 20; k++) begin
                if (!(mem_en && core_reset)) break;
                cnt++;
                if (poke && k == 1) boot_start = 1'b1;
                step();
                boot_start = 1'b0;
            end
            check_val("settle_cycles", 32'(cnt), 32'(c_rel));
            check_val("run_core_reset", 32'(core_reset), 32'd0);
            check_val("run_mem_en", 32'(mem_en), 32'd1);
            check_val("run_boot_done", 32'(boot_done), 32'd1);
            if (poke) begin
                boot_start = 1'b1;
                step();
                boot_start = 1'b0;
                step();
                check_val("run_poke_done", 32'(boot_done), 32'd1);
                check_val("run_poke_reset", 32'(core_reset), 32'd0);
                check_val("run_poke_ready", 32'(ld_ready), 32'd0);
            end
            step();
        end
        check_val("write_count", 32'(n_writes), 32'(n_exp));
        check_val("writes_pending", 32'(exp_q.size()), 32'd0);
        check_val("final_count", 32'(words_loaded), 32'(n_exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w1;
        bit          ok;
        reset      = 1'b1;
        boot_start = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 32'h0;
        ld_last    = 1'b0;
        do_reset();

        // Known three-word program, with boot_start poked in SETTLE and RUN
        run_load(3, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        do_reset();

        // Valid low every other cycle
        run_load(6, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Random lengths and random gaps
        for (int t = 0; t < 6; t++) begin
            run_load(int'($urandom_range(1, 12)), 1'b1, -1, 1'b0, 1'b0, 1'b0);
            do_reset();
        end

        // Exactly full region is legal
        run_load(c_max, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Overflow, then restart from ERROR with a short stream
        run_load(c_max + 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_load(2, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        do_reset();

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum beat
        run_load(2, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        do_reset();
`endif

        // Reset arriving while the second word is on the bus
        exp_q.delete();
        n_writes   = 0;
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
        w1 = $urandom;
        exp_q.push_back({c_start, w1});
        send_beat(w1, 1'b0, 0, ok);
        ld_valid = 1'b1;
        ld_data  = $urandom;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        step();
        step();
        check_val("abort_no_write", 32'(mem_wr_en), 32'd0);
        reset = 1'b0;
        step();
        ld_valid = 1'b0;
        step();
        check_val("abort_write_count", 32'(n_writes), 32'd1);
        check_val("abort_idle_ready", 32'(ld_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
